// File: rtl/edge_thresh_adapt_pkg.sv
// Shared widths, defaults and FSM encoding for the adaptive edge-threshold stage.
package edge_thresh_adapt_pkg;

  localparam int MAG_W_DEF    = 8;
  localparam int PIX_W_DEF    = 17;
  localparam int GAIN_Q2_DEF  = 6;
  localparam int THR_INIT_DEF = 32;
  localparam int THR_MIN_DEF  = 16;
  localparam int THR_MAX_DEF  = 224;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_SCALE = 2'd2
  } div_state_e;

  // Accumulator must hold a full frame of saturated-count magnitudes.
  function automatic int sum_width(input int mag_w, input int pix_w);
    return mag_w + pix_w;
  endfunction

endpackage

// File: rtl/edge_thresh_adapt_seq_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, DVD_W cycles after start, done pulses once.
module edge_thresh_adapt_seq_udiv #(
  parameter int DVD_W = 25,
  parameter int DVS_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVD_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [DVS_W:0]   partial;
  logic             ge;

  // Remainder stays below the divisor, so the shifted partial fits in DVS_W+1 bits.
  assign partial = {rem_q, quo_q[DVD_W-1]};
  assign ge      = partial >= {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        rem_q  <= '0;
        quo_q  <= dividend_i;
        dvs_q  <= divisor_i;
        cnt_q  <= CNT_W'(DVD_W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= ge ? DVS_W'(partial - {1'b0, dvs_q}) : partial[DVS_W-1:0];
        quo_q <= {quo_q[DVD_W-2:0], ge};
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/edge_thresh_adapt.sv
// Binarizes edge magnitudes against a threshold re-derived each frame from 1.5x the mean magnitude.
module edge_thresh_adapt
  import edge_thresh_adapt_pkg::*;
#(
  parameter int MAG_W    = MAG_W_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int GAIN_Q2  = GAIN_Q2_DEF,
  parameter int THR_INIT = THR_INIT_DEF,
  parameter int THR_MIN  = THR_MIN_DEF,
  parameter int THR_MAX  = THR_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_valid_i,
  input  logic [MAG_W-1:0] edge_magnitude_i,
  input  logic             frame_start_i,
  input  logic             frame_end_i,
  input  logic             thr_manual_en_i,
  input  logic [MAG_W-1:0] thr_manual_i,
  output logic             bin_valid_o,
  output logic [MAG_W-1:0] bin_pixel_o,
  output logic [MAG_W-1:0] thr_active_o,
  output logic             thr_update_o,
  output logic             div_busy_o,
  output logic             overrun_o
);

  localparam int SUM_W  = sum_width(MAG_W, PIX_W);
  localparam int PROD_W = SUM_W + 4;

  logic             bin_valid_q;
  logic [MAG_W-1:0] bin_pixel_q;
  logic [MAG_W-1:0] thr_active_q;
  logic             thr_update_q;
  logic [MAG_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             overrun_q;
  logic [SUM_W-1:0] sum_q, sum_d, sum_cur;
  logic [PIX_W-1:0] cnt_q, cnt_d, cnt_cur;
  div_state_e       state_q, state_d;
  logic [MAG_W-1:0] thr_sel;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] quotient;
  logic [PROD_W-1:0] prod;
  logic [MAG_W-1:0] thr_calc;

  assign thr_sel = thr_manual_en_i ? thr_manual_i : thr_active_q;

  // Frame start clears first, then the same-cycle pixel, then frame end snapshots the result.
  always_comb begin
    sum_cur = frame_start_i ? '0 : sum_q;
    cnt_cur = frame_start_i ? '0 : cnt_q;
    if (edge_valid_i && !(&cnt_cur)) begin
      sum_cur = sum_cur + SUM_W'(edge_magnitude_i);
      cnt_cur = cnt_cur + PIX_W'(1);
    end
    sum_d = frame_end_i ? '0 : sum_cur;
    cnt_d = frame_end_i ? '0 : cnt_cur;
  end

  assign div_start = frame_end_i && (state_q == ST_IDLE) && (cnt_cur != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (div_start) state_d = ST_DIV;
      ST_DIV:   if (div_done) state_d = ST_SCALE;
      ST_SCALE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  edge_thresh_adapt_seq_udiv #(
    .DVD_W (SUM_W),
    .DVS_W (PIX_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (sum_cur),
    .divisor_i  (cnt_cur),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  // Clamp is evaluated on the Q2 product so the two fraction bits never need a separate shift.
  assign prod = PROD_W'(quotient) * PROD_W'(GAIN_Q2);

  always_comb begin
    if (prod < PROD_W'(THR_MIN * 4))
      thr_calc = MAG_W'(THR_MIN);
    else if (prod > PROD_W'(THR_MAX * 4 + 3))
      thr_calc = MAG_W'(THR_MAX);
    else
      thr_calc = prod[MAG_W+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_valid_q  <= 1'b0;
      bin_pixel_q  <= '0;
      thr_active_q <= MAG_W'(THR_INIT);
      thr_update_q <= 1'b0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      overrun_q    <= 1'b0;
      sum_q        <= '0;
      cnt_q        <= '0;
      state_q      <= ST_IDLE;
    end else begin
      bin_valid_q  <= edge_valid_i;
      bin_pixel_q  <= (edge_valid_i && (edge_magnitude_i >= thr_sel)) ? '1 : '0;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      thr_update_q <= 1'b0;
      if (frame_start_i && pend_vld_q) begin
        thr_active_q <= pend_q;
        thr_update_q <= 1'b1;
        pend_vld_q   <= 1'b0;
      end
      // A fresh result lands after any same-cycle apply, so it waits for the following frame.
      if (state_q == ST_SCALE) begin
        pend_q     <= thr_calc;
        pend_vld_q <= 1'b1;
      end
      if (frame_end_i && (state_q != ST_IDLE))
        overrun_q <= 1'b1;
    end
  end

  assign bin_valid_o  = bin_valid_q;
  assign bin_pixel_o  = bin_pixel_q;
  assign thr_active_o = thr_active_q;
  assign thr_update_o = thr_update_q;
  assign div_busy_o   = (state_q != ST_IDLE);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_edge_thresh_adapt.sv
// Directed plus randomized frames checked cycle-by-cycle against a frame-level threshold model.
module tb_edge_thresh_adapt;

  localparam int MAXC    = (1 << 17) - 1;
  localparam int LATENCY = 8 + 17 + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       edge_valid = 1'b0;
  logic [7:0] edge_mag = '0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       thr_manual_en = 1'b0;
  logic [7:0] thr_manual = '0;
  logic       bin_valid_o;
  logic [7:0] bin_pixel_o;
  logic [7:0] thr_active_o;
  logic       thr_update_o;
  logic       div_busy_o;
  logic       overrun_o;

  int n_vec = 0;
  int n_fail = 0;

  int   m_thr, m_pend, m_sum, m_cnt, m_busy, m_res;
  logic m_pend_vld, m_ovr;

  edge_thresh_adapt dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .edge_valid_i     (edge_valid),
    .edge_magnitude_i (edge_mag),
    .frame_start_i    (frame_start),
    .frame_end_i      (frame_end),
    .thr_manual_en_i  (thr_manual_en),
    .thr_manual_i     (thr_manual),
    .bin_valid_o      (bin_valid_o),
    .bin_pixel_o      (bin_pixel_o),
    .thr_active_o     (thr_active_o),
    .thr_update_o     (thr_update_o),
    .div_busy_o       (div_busy_o),
    .overrun_o        (overrun_o)
  );

  always #5 clk = ~clk;

  function automatic int calc_thr(input int s, input int c);
    int t;
    t = ((s / c) * 6) / 4;
    if (t < 16) t = 16;
    if (t > 224) t = 224;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_thr = 32; m_pend = 0; m_pend_vld = 1'b0;
    m_sum = 0; m_cnt = 0; m_busy = 0; m_res = 0; m_ovr = 1'b0;
  endtask

  task automatic check_all(input logic e_bv, input int e_pix, input logic e_upd);
    chk("bin_valid", 32'(bin_valid_o), 32'(e_bv));
    chk("bin_pixel", 32'(bin_pixel_o), 32'(e_pix));
    chk("thr_active", 32'(thr_active_o), 32'(m_thr));
    chk("thr_update", 32'(thr_update_o), 32'(e_upd));
    chk("div_busy", 32'(div_busy_o), 32'(m_busy > 0));
    chk("overrun", 32'(overrun_o), 32'(m_ovr));
  endtask

  task automatic step(input logic ev, input int mag, input logic fs, input logic fe);
    int   sel, e_pix;
    logic e_upd, was_busy;
    edge_valid = ev; edge_mag = mag[7:0]; frame_start = fs; frame_end = fe;
    sel   = thr_manual_en ? int'(thr_manual) : m_thr;
    e_pix = (ev && mag >= sel) ? 255 : 0;
    e_upd = 1'b0;
    if (fs && m_pend_vld) begin
      m_thr = m_pend; m_pend_vld = 1'b0; e_upd = 1'b1;
    end
    if (fs) begin m_sum = 0; m_cnt = 0; end
    if (ev && m_cnt < MAXC) begin m_sum += mag; m_cnt++; end
    was_busy = (m_busy > 0);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_pend = m_res; m_pend_vld = 1'b1; end
    end
    if (fe) begin
      if (was_busy) m_ovr = 1'b1;
      else if (m_cnt != 0) begin m_res = calc_thr(m_sum, m_cnt); m_busy = LATENCY; end
      m_sum = 0; m_cnt = 0;
    end
    @(posedge clk); #1;
    check_all(ev, e_pix, e_upd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int n, input int mag);
    step(1'b1, mag, 1'b1, 1'b0);
    for (int i = 1; i < n; i++) step(1'b1, mag, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; edge_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    #2;
    model_reset();
    check_all(1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int npix, lo, hi;
    #1;
    do_reset();
    chk("rst_thr_init", 32'(thr_active_o), 32);

    step(1'b1, 31, 1'b0, 1'b0);
    chk("mag31", 32'(bin_pixel_o), 0);
    step(1'b1, 32, 1'b0, 1'b0);
    chk("mag32", 32'(bin_pixel_o), 255);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("bin_valid_drop", 32'(bin_valid_o), 0);

    frame(16, 100);
    idle(26);
    chk("busy_at_26", 32'(div_busy_o), 1);
    idle(10);
    chk("thr_held", 32'(thr_active_o), 32);
    frame(16, 250);
    chk("thr_150", 32'(thr_active_o), 150);
    idle(30);
    frame(16, 4);
    chk("thr_clamp_hi", 32'(thr_active_o), 224);
    idle(30);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("thr_clamp_lo", 32'(thr_active_o), 16);

    idle(3);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(5);
    chk("no_div_empty", 32'(div_busy_o), 0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("thr_unchanged", 32'(thr_active_o), 16);

    frame(16, 80);
    idle(4);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("overrun_set", 32'(overrun_o), 1);
    idle(30);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("thr_after_ovr", 32'(thr_active_o), 120);

    frame(16, 200);
    idle(10);
    do_reset();
    idle(40);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("thr_after_abort", 32'(thr_active_o), 32);

    thr_manual_en = 1'b1; thr_manual = 8'd200;
    step(1'b1, 199, 1'b0, 1'b0);
    chk("manual_199", 32'(bin_pixel_o), 0);
    step(1'b1, 200, 1'b0, 1'b0);
    chk("manual_200", 32'(bin_pixel_o), 255);
    frame(16, 100);
    idle(30);
    step(1'b1, 150, 1'b1, 1'b0);
    chk("manual_adapt", 32'(thr_active_o), 150);
    chk("manual_pix", 32'(bin_pixel_o), 0);
    thr_manual_en = 1'b0;

    for (int f = 0; f < 40; f++) begin
      thr_manual_en = ($urandom_range(0, 3) == 0);
      thr_manual = 8'($urandom_range(0, 255));
      npix = $urandom_range(0, 30);
      lo = $urandom_range(0, 200);
      hi = lo + $urandom_range(0, 55);
      step(1'($urandom_range(0, 1)), $urandom_range(lo, hi), 1'b1, 1'b0);
      for (int i = 0; i < npix; i++)
        step(1'($urandom_range(0, 3) != 0), $urandom_range(lo, hi), 1'b0, 1'b0);
      step(1'($urandom_range(0, 1)), $urandom_range(lo, hi), 1'b0, 1'b1);
      idle($urandom_range(0, 40));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
